// File: rtl/nand_gate_arbiter.sv
// Round-robin arbiter that time-shares one external NAND gate between N_REQ requesters.
// Each grant drives the operands to the gate. The result is captured one cycle later and held until it is consumed.
module nand_gate_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic [WIDTH-1:0]           gate_a,
    output logic [WIDTH-1:0]           gate_b,
    input  logic [WIDTH-1:0]           gate_y,
    output logic                       rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    input  logic                       rsp_ready,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] last_grant;

    logic            grant_any;
    logic [ID_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_oh;
    logic [ID_W:0]   cand;

    // Round-robin search: walk from last_grant+1 upward, wrapping at N_REQ, and take the first valid requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, last_grant} + (ID_W+1)'(k + 1);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    assign grant_oh = N_REQ'(1) << grant_idx;

    // Handshakes: a request transfers on a rising edge where req_valid[i] and req_ready[i] are both high.
    // A result transfers on a rising edge where rsp_valid and rsp_ready are both high.
    // req_ready is a combinational grant that is offered only in IDLE and only to a valid requester.
    // It is held low during reset, so a stale request cannot be accepted while reset is asserted.
    assign req_ready = (rst && state == IDLE && grant_any) ? grant_oh : '0;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            gate_a     <= '0;
            gate_b     <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        gate_a     <= req_a[grant_idx*WIDTH +: WIDTH];
                        gate_b     <= req_b[grant_idx*WIDTH +: WIDTH];
                        rsp_id     <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    rsp_data  <= gate_y;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_gate_arbiter.sv
// Self-checking bench for nand_gate_arbiter: directed corner cases plus randomized transactions.
// Results are checked against a round-robin reference model and a scoreboard queue.
module tb_nand_gate_arbiter;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int ID_W  = $clog2(N_REQ);

    logic                     clk;
    logic                     rst;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*WIDTH-1:0]   req_a;
    logic [N_REQ*WIDTH-1:0]   req_b;
    logic [N_REQ-1:0]         req_ready;
    logic [WIDTH-1:0]         gate_a;
    logic [WIDTH-1:0]         gate_b;
    logic [WIDTH-1:0]         gate_y;
    logic                     rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic                     rsp_ready;
    logic                     busy;
    logic [1:0]               dbg_state;

    logic [WIDTH-1:0] a_op [N_REQ];
    logic [WIDTH-1:0] b_op [N_REQ];

    int tests;
    int fails;
    int cyc;
    int prev_grant_cyc;
    int model_last;

    logic [WIDTH-1:0] exp_q [$];
    int               id_q  [$];

    nand_gate_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .gate_a    (gate_a),
        .gate_b    (gate_b),
        .gate_y    (gate_y),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // The shared external NAND gate.
    assign gate_y = ~(gate_a & gate_b);

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = a_op[i];
            req_b[i*WIDTH +: WIDTH] = b_op[i];
        end
    end

    // Clock / reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: scan from last+1 in ring order, first valid wins.
    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input int idx);
        logic [N_REQ-1:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < N_REQ; i++) begin
            a_op[i] = WIDTH'($urandom);
            b_op[i] = WIDTH'($urandom);
        end
    endtask

    task automatic set_all_ops(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int i = 0; i < N_REQ; i++) begin
            a_op[i] = a;
            b_op[i] = b;
        end
    endtask

    // Driver: called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_txn(input logic [N_REQ-1:0] v, input int stall, input bit chk_gap);
        int idx;
        int exp_id;
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] ga;
        logic [WIDTH-1:0] gb;
        req_valid = v;
        rsp_ready = (stall == 0);
        #1;
        idx = rr_pick(v, model_last);
        check("req_ready_grant", 32'(req_ready), 32'(onehot(idx)));
        check("busy_idle", 32'(busy), 32'd0);
        if (chk_gap) check("issue_gap", 32'(cyc - prev_grant_cyc), 32'd3);
        prev_grant_cyc = cyc;
        model_last = idx;
        ga = a_op[idx];
        gb = b_op[idx];
        exp_q.push_back(~(ga & gb));
        id_q.push_back(idx);

        @(negedge clk);
        check("req_ready_eval", 32'(req_ready), 32'd0);
        check("gate_a", 32'(gate_a), 32'(ga));
        check("gate_b", 32'(gate_b), 32'(gb));
        check("busy_eval", 32'(busy), 32'd1);
        check("rsp_valid_eval", 32'(rsp_valid), 32'd0);

        @(negedge clk);
        e = exp_q.pop_front();
        exp_id = id_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(e));
        check("rsp_id", 32'(rsp_id), 32'(exp_id));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", 32'(rsp_data), 32'(e));
            check("stall_id", 32'(rsp_id), 32'(exp_id));
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_gate_a", 32'(gate_a), 32'(ga));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_done_valid", 32'(rsp_valid), 32'd0);
        check("rsp_done_busy", 32'(busy), 32'd0);
        check("gate_hold", 32'(gate_b), 32'(gb));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_last = N_REQ - 1;
        prev_grant_cyc = 0;
        rst = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '1;
        randomize_ops();

        // Reset state, with requests pending that must not be accepted.
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_gate_a", 32'(gate_a), 32'd0);
        check("rst_gate_b", 32'(gate_b), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        check("idle_no_req", 32'(req_ready), 32'd0);

        // Single request to requester 0.
        a_op[0] = 8'hF0;
        b_op[0] = 8'hFF;
        run_txn(4'b0001, 0, 1'b0);
        check("single_0f", 32'(rsp_data), 32'h0F);

        // All requesters continuously valid: ring order and 3-cycle issue spacing.
        randomize_ops();
        for (int t = 0; t < 6; t++) run_txn(4'b1111, 0, t != 0);

        // Back-pressure for 5 cycles.
        randomize_ops();
        run_txn(4'b1111, 5, 1'b0);

        // Pointer wrap.
        run_txn(4'b1000, 0, 1'b0);
        check("wrap_last3", 32'(rsp_id), 32'd3);
        run_txn(4'b1001, 0, 1'b0);
        check("wrap_to0", 32'(rsp_id), 32'd0);
        run_txn(4'b1001, 0, 1'b0);
        check("wrap_to3", 32'(rsp_id), 32'd3);

        // Operand corners.
        set_all_ops(8'h00, 8'h00);
        run_txn(4'b1111, 0, 1'b0);
        check("corner_00", 32'(rsp_data), 32'hFF);
        set_all_ops(8'hFF, 8'hFF);
        run_txn(4'b1111, 1, 1'b0);
        check("corner_ff", 32'(rsp_data), 32'h00);
        set_all_ops(8'hAA, 8'h55);
        run_txn(4'b1111, 0, 1'b0);
        check("corner_aa55", 32'(rsp_data), 32'hFF);

        // Reset while in EVAL aborts the transaction.
        set_all_ops(8'hC3, 8'h5A);
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        check("pre_abort_grant", 32'(req_ready), 32'(onehot(rr_pick(4'b1111, model_last))));
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_data", 32'(rsp_data), 32'd0);
        check("abort_rsp_id", 32'(rsp_id), 32'd0);
        check("abort_gate_a", 32'(gate_a), 32'd0);
        check("abort_gate_b", 32'(gate_b), 32'd0);
        check("abort_busy0", 32'(busy), 32'd0);
        model_last = N_REQ - 1;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_abort_valid", 32'(rsp_valid), 32'd0);
            check("post_abort_busy", 32'(busy), 32'd0);
        end
        run_txn(4'b1111, 0, 1'b0);
        check("post_abort_id0", 32'(rsp_id), 32'd0);

        // Randomized transactions with idle gaps.
        for (int t = 0; t < 24; t++) begin
            randomize_ops();
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                @(negedge clk);
                check("rand_idle_ready", 32'(req_ready), 32'd0);
                check("rand_idle_busy", 32'(busy), 32'd0);
                check("rand_idle_valid", 32'(rsp_valid), 32'd0);
            end
            run_txn(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), $urandom_range(0, 3), 1'b0);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
